// File: rtl/charge_pkg.sv
// Shared types and helpers for the charge keeper array: storage strength,
// per-channel cell state and retention-length lookup.
package charge_pkg;

  typedef enum logic [1:0] {
    STR_SMALL  = 2'b00,
    STR_MEDIUM = 2'b01,
    STR_LARGE  = 2'b10,
    STR_INF    = 2'b11
  } strength_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    DRIVEN = 2'b01,
    HELD   = 2'b10
  } cell_state_t;

  // Retention length in cycles for a finite strength; 0 for infinite.
  function automatic int unsigned hold_cycles(strength_t s, int unsigned hold_small,
                                              int unsigned hold_medium,
                                              int unsigned hold_large);
    case (s)
      STR_SMALL:  return hold_small;
      STR_MEDIUM: return hold_medium;
      STR_LARGE:  return hold_large;
      default:    return 0;
    endcase
  endfunction

endpackage

// File: rtl/charge_cell.sv
// One keeper channel: follows its input while driven, retains the last value
// for a strength-dependent number of cycles once released, then discharges.
module charge_cell
  import charge_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HOLD_SMALL  = 4,
  parameter int unsigned HOLD_MEDIUM = 16,
  parameter int unsigned HOLD_LARGE  = 64,
  parameter int unsigned CNT_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             control_i,
  input  strength_t        strength_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             held_o,
  output logic             pulse_o
);

  cell_state_t      state_q, state_d;
  strength_t        str_q, str_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             pulse_q, pulse_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      str_q   <= STR_SMALL;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      str_q   <= str_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    str_d   = str_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    held_d  = held_q;
    pulse_d = 1'b0;
    if (control_i) begin
      state_d = DRIVEN;
      data_d  = data_i;
      valid_d = 1'b1;
      held_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DRIVEN: begin
          // Strength is latched here; later changes cannot shorten the hold.
          state_d = HELD;
          held_d  = 1'b1;
          str_d   = strength_i;
          cnt_d   = (strength_i == STR_INF) ? '0 :
                    CNT_W'(hold_cycles(strength_i, HOLD_SMALL, HOLD_MEDIUM, HOLD_LARGE) - 1);
        end
        HELD: begin
          if (str_q != STR_INF) begin
            if (cnt_q == '0) begin
              state_d = EMPTY;
              data_d  = '0;
              valid_d = 1'b0;
              held_d  = 1'b0;
              pulse_d = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = EMPTY;
          data_d  = '0;
          valid_d = 1'b0;
          held_d  = 1'b0;
        end
      endcase
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign held_o  = held_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/charge_keeper_array.sv
// Array of independent keeper channels sharing one clock and reset; slices the
// flat buses into per-channel cells.
module charge_keeper_array
  import charge_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned HOLD_SMALL  = 4,
  parameter int unsigned HOLD_MEDIUM = 16,
  parameter int unsigned HOLD_LARGE  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [CHANNELS-1:0]       control,
  input  logic [2*CHANNELS-1:0]     strength,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [CHANNELS-1:0]       out_valid,
  output logic [CHANNELS-1:0]       held,
  output logic [CHANNELS-1:0]       decay_pulse
);

  // Guard keeps the counter at least one bit wide for a one-cycle large hold.
  localparam int unsigned CNT_W = (HOLD_LARGE > 1) ? $clog2(HOLD_LARGE) : 1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    charge_cell #(
      .WIDTH      (WIDTH),
      .HOLD_SMALL (HOLD_SMALL),
      .HOLD_MEDIUM(HOLD_MEDIUM),
      .HOLD_LARGE (HOLD_LARGE),
      .CNT_W      (CNT_W)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .data_i    (in[c*WIDTH +: WIDTH]),
      .control_i (control[c]),
      .strength_i(strength_t'(strength[2*c +: 2])),
      .data_o    (out[c*WIDTH +: WIDTH]),
      .valid_o   (out_valid[c]),
      .held_o    (held[c]),
      .pulse_o   (decay_pulse[c])
    );
  end

endmodule

// File: tb/tb_charge_keeper_array.sv
// Scoreboard bench for charge_keeper_array: stimulus queues per-cycle
// expectations, a monitor compares them after each rising edge.
module tb_charge_keeper_array;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 4;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [CHANNELS*WIDTH-1:0] in_d = '0;
  logic [CHANNELS-1:0]       control = '0;
  logic [2*CHANNELS-1:0]     strength = '0;
  logic [CHANNELS*WIDTH-1:0] out;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       held;
  logic [CHANNELS-1:0]       decay_pulse;

  always #5 clk = ~clk;

  charge_keeper_array #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS),
    .HOLD_SMALL(4), .HOLD_MEDIUM(16), .HOLD_LARGE(64)
  ) dut (
    .clk(clk), .rst(rst), .in(in_d), .control(control), .strength(strength),
    .out(out), .out_valid(out_valid), .held(held), .decay_pulse(decay_pulse)
  );

  typedef struct {
    int         cyc;
    int         ch;
    logic [7:0] dat;
    logic       v;
    logic       h;
    logic       p;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void expect_at(int d, int ch, logic [7:0] dat, logic v, logic h,
                                    logic p, string name);
    exp_t e;
    e.cyc = cyc + d; e.ch = ch; e.dat = dat; e.v = v; e.h = h; e.p = p; e.name = name;
    sb.push_back(e);
  endfunction

  // Held for H cycles after the release edge, then one pulse, then empty.
  function automatic void hold_check(int ch, logic [7:0] dat, int hc, string name);
    for (int k = 1; k <= hc; k++) expect_at(k, ch, dat, 1'b1, 1'b1, 1'b0, name);
    expect_at(hc + 1, ch, 8'h00, 1'b0, 1'b0, 1'b1, {name, "_pulse"});
    expect_at(hc + 2, ch, 8'h00, 1'b0, 1'b0, 1'b0, {name, "_after"});
  endfunction

  // Monitor: after each rising edge, compare every expectation due this cycle.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          logic [7:0] ao;
          ao = out[sb[i].ch*WIDTH +: WIDTH];
          n_cmp++;
          if ({ao, out_valid[sb[i].ch], held[sb[i].ch], decay_pulse[sb[i].ch]} !==
              {sb[i].dat, sb[i].v, sb[i].h, sb[i].p}) begin
            n_err++;
            $display("FAIL %s ch%0d cyc%0d: got out=%h v=%b h=%b p=%b, want out=%h v=%b h=%b p=%b",
                     sb[i].name, sb[i].ch, cyc, ao, out_valid[sb[i].ch], held[sb[i].ch],
                     decay_pulse[sb[i].ch], sb[i].dat, sb[i].v, sb[i].h, sb[i].p);
          end
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks pending", sb.size());
    $fatal(1, "watchdog");
  end

  task automatic nxt(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(int ch, logic [7:0] d);
    control[ch] = 1'b1;
    in_d[ch*WIDTH +: WIDTH] = d;
  endtask

  task automatic rel(int ch, logic [1:0] s);
    control[ch] = 1'b0;
    strength[2*ch +: 2] = s;
  endtask

  logic [7:0] dat6 [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
  int         hc6  [3] = '{4, 16, 64};

  initial begin
    // Reset state on all channels
    nxt(1);
    for (int c = 0; c < CHANNELS; c++) expect_at(1, c, 8'h00, 1'b0, 1'b0, 1'b0, "reset");
    nxt(1);
    rst = 1'b0;

    // Drive 0xA5 for three cycles
    drive(0, 8'hA5);
    for (int d = 1; d <= 3; d++) expect_at(d, 0, 8'hA5, 1'b1, 1'b0, 1'b0, "drive_a5");
    nxt(3);

    // Small hold
    drive(0, 8'h3C);
    expect_at(1, 0, 8'h3C, 1'b1, 1'b0, 1'b0, "drive_3c");
    nxt(1);
    rel(0, 2'b00);
    hold_check(0, 8'h3C, 4, "small");
    for (int c = 1; c < CHANNELS; c++) expect_at(5, c, 8'h00, 1'b0, 1'b0, 1'b0, "idle_ch");
    nxt(6);

    // Medium hold interrupted by re-drive, then full restart
    drive(0, 8'h77);
    expect_at(1, 0, 8'h77, 1'b1, 1'b0, 1'b0, "drive_77");
    nxt(1);
    rel(0, 2'b01);
    for (int d = 1; d <= 10; d++) expect_at(d, 0, 8'h77, 1'b1, 1'b1, 1'b0, "med_pre");
    nxt(10);
    drive(0, 8'h11);
    expect_at(1, 0, 8'h11, 1'b1, 1'b0, 1'b0, "reassert");
    nxt(1);
    rel(0, 2'b01);
    hold_check(0, 8'h11, 16, "med_restart");
    nxt(18);

    // Large hold ignores strength change during HELD
    drive(0, 8'hC3);
    expect_at(1, 0, 8'hC3, 1'b1, 1'b0, 1'b0, "drive_c3");
    nxt(1);
    rel(0, 2'b10);
    hold_check(0, 8'hC3, 64, "large");
    nxt(2);
    strength[1:0] = 2'b00;
    nxt(64);

    // Infinite hold
    drive(0, 8'h5A);
    expect_at(1, 0, 8'h5A, 1'b1, 1'b0, 1'b0, "drive_5a");
    nxt(1);
    rel(0, 2'b11);
    for (int d = 1; d <= 1100; d++) expect_at(d, 0, 8'h5A, 1'b1, 1'b1, 1'b0, "inf");
    nxt(1100);

    // Reset in the middle of a medium hold
    drive(0, 8'h99);
    expect_at(1, 0, 8'h99, 1'b1, 1'b0, 1'b0, "drive_99");
    nxt(1);
    rel(0, 2'b01);
    for (int d = 1; d <= 3; d++) expect_at(d, 0, 8'h99, 1'b1, 1'b1, 1'b0, "med_rst_pre");
    nxt(3);
    rst = 1'b1;
    for (int c = 0; c < CHANNELS; c++) expect_at(1, c, 8'h00, 1'b0, 1'b0, 1'b0, "rst_mid");
    nxt(1);
    rst = 1'b0;
    expect_at(1, 0, 8'h00, 1'b0, 1'b0, 1'b0, "post_rst");
    expect_at(2, 0, 8'h00, 1'b0, 1'b0, 1'b0, "post_rst2");
    nxt(2);

    // Four channels released together with different strengths
    for (int c = 0; c < CHANNELS; c++) begin
      drive(c, dat6[c]);
      expect_at(1, c, dat6[c], 1'b1, 1'b0, 1'b0, "multi_drive");
    end
    nxt(1);
    for (int c = 0; c < CHANNELS; c++) rel(c, 2'(c));
    for (int c = 0; c < 3; c++) hold_check(c, dat6[c], hc6[c], "multi");
    for (int d = 1; d <= 80; d++) expect_at(d, 3, dat6[3], 1'b1, 1'b1, 1'b0, "multi_inf");
    nxt(80);

    nxt(3);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL leftover: got %0d unchecked expectations, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
